// File: rtl/semaforo_arbitro.sv
// semaforo_arbitro: timed two-street intersection controller.
// Schedules right-of-way between streets A and B with minimum/maximum green,
// yellow and all-red clearance, and a pedestrian walk phase with request
// latch and one-cycle acknowledge. Outputs are a Moore decode of the state.
module semaforo_arbitro #(
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 12,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 6,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,      // asynchronous, active-low
  input  logic       TA,
  input  logic       TB,
  input  logic       PED_REQ,
  output logic       PED_ACK,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       WALK,
  output logic [2:0] PHASE
);

  typedef enum logic [2:0] {
    AG = 3'd0,
    AY = 3'd1,
    AR = 3'd2,
    BG = 3'd3,
    BY = 3'd4,
    BR = 3'd5,
    WK = 3'd6
  } state_t;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Terminal counts: a phase ends in the cycle where cnt reaches these.
  localparam logic [CNT_W-1:0] MIN_END    = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_END    = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YELLOW_END = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_END = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_END   = CNT_W'(WALK_CYC - 1);

  // last_q encoding: which street held the most recent green.
  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_q, ped_d;
  logic             last_q, last_d;

  logic             leave_ag, leave_bg;

  // State, phase counter, pedestrian latch and last-green flag registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AG;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      last_q  <= LAST_A;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      last_q  <= last_d;
    end
  end

  // Green exit conditions: minimum served, then cross demand, max-green
  // contention timeout, or a pending pedestrian request.
  always_comb begin
    leave_ag = (cnt_q >= MIN_END) &&
               ((TB && !TA) || (TB && (cnt_q == MAX_END)) || ped_q);
    leave_bg = (cnt_q >= MIN_END) &&
               ((TA && !TB) || (TA && (cnt_q == MAX_END)) || ped_q);
  end

  // Next-state, counter, latch and flag update.
  // NOTE: every variable gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    last_d  = last_q;

    unique case (state_q)
      AG: if (leave_ag)                state_d = AY;
      AY: if (cnt_q == YELLOW_END)     state_d = AR;
      AR: if (cnt_q == ALLRED_END)     state_d = ped_q ? WK : BG;
      BG: if (leave_bg)                state_d = BY;
      BY: if (cnt_q == YELLOW_END)     state_d = BR;
      BR: if (cnt_q == ALLRED_END)     state_d = ped_q ? WK : AG;
      WK: if (cnt_q == WALK_END)       state_d = (last_q == LAST_A) ? BG : AG;
      default:                         state_d = AG;
    endcase

    // Counter restarts on every phase change; greens saturate at max.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (((state_q == AG) || (state_q == BG)) && (cnt_q == MAX_END)) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // Requests during the walk are dropped; clearing on walk entry beats a
    // request arriving in the same cycle.
    if (state_q != WK && PED_REQ) ped_d = 1'b1;
    if (state_d == WK && state_q != WK) ped_d = 1'b0;

    if (state_d == AG && state_q != AG) last_d = LAST_A;
    if (state_d == BG && state_q != BG) last_d = LAST_B;
  end

  // Moore output decode from the state register.
  always_comb begin
    LA      = RED;
    LB      = RED;
    WALK    = 1'b0;
    PED_ACK = 1'b0;
    PHASE   = state_q;
    unique case (state_q)
      AG: LA = GREEN;
      AY: LA = YELLOW;
      BG: LB = GREEN;
      BY: LB = YELLOW;
      WK: begin
        WALK    = 1'b1;
        PED_ACK = (cnt_q == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_semaforo_arbitro.sv
// tb_semaforo_arbitro: directed-vector bench for semaforo_arbitro with
// hand-computed phase sequences and a per-cycle light exclusivity check.
module tb_semaforo_arbitro;

  logic       clk;
  logic       rst;
  logic       ta, tb, ped_req;
  logic       ped_ack;
  logic [1:0] la, lb;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  semaforo_arbitro dut (
    .clk     (clk),
    .rst     (rst),
    .TA      (ta),
    .TB      (tb),
    .PED_REQ (ped_req),
    .PED_ACK (ped_ack),
    .LA      (la),
    .LB      (lb),
    .WALK    (walk),
    .PHASE   (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, act, exp);
    end
  endtask

  // Light codes for each phase, straight from the state table.
  function automatic int unsigned exp_la(input int unsigned p);
    case (p)
      0: exp_la = 0;
      1: exp_la = 1;
      default: exp_la = 2;
    endcase
  endfunction

  function automatic int unsigned exp_lb(input int unsigned p);
    case (p)
      3: exp_lb = 0;
      4: exp_lb = 1;
      default: exp_lb = 2;
    endcase
  endfunction

  task automatic check_cycle(input string tag, input int unsigned p, input int unsigned ack);
    check({tag, ".phase"}, phase, p);
    check({tag, ".la"}, la, exp_la(p));
    check({tag, ".lb"}, lb, exp_lb(p));
    check({tag, ".walk"}, walk, (p == 6) ? 1 : 0);
    check({tag, ".ack"}, ped_ack, ack);
  endtask

  // Both streets may never be non-red at the same time.
  always @(negedge clk) begin
    check("excl", ((la != 2'b10) && (lb != 2'b10)) ? 1 : 0, 0);
  end

  // Hold reset, check the reset state, release just after an edge so the
  // next edge closes cycle 0.
  task automatic do_reset();
    rst = 1'b0; ta = 1'b0; tb = 1'b0; ped_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cycle("rst", 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; ta = 1'b0; tb = 1'b0; ped_req = 1'b0;

    // A-only traffic: green stays on A.
    do_reset();
    for (int k = 0; k < 50; k++) begin
      ta = 1'b1; tb = 1'b0;
      @(negedge clk); check_cycle("a_only", 0, 0);
      next_cycle();
    end

    // B-only traffic: AG 0-3, AY 4-6, AR 7, BG from 8.
    do_reset();
    for (int k = 0; k < 14; k++) begin
      int unsigned p;
      ta = 1'b0; tb = 1'b1;
      p = (k < 4) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : 3;
      @(negedge clk); check_cycle("b_only", p, 0);
      next_cycle();
    end

    // Continuous contention: 12/3/1/12/3/1, period 32.
    do_reset();
    for (int k = 0; k < 64; k++) begin
      int unsigned p, m;
      ta = 1'b1; tb = 1'b1;
      m = k % 32;
      p = (m < 12) ? 0 : (m < 15) ? 1 : (m == 15) ? 2 :
          (m < 28) ? 3 : (m < 31) ? 4 : 5;
      @(negedge clk); check_cycle("contend", p, 0);
      next_cycle();
    end

    // One-cycle pedestrian request at cycle 1: walk 8-13, BG from 14.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      int unsigned p;
      ta = 1'b1; tb = 1'b0; ped_req = (k == 1);
      p = (k < 4) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : (k < 14) ? 6 : 3;
      @(negedge clk); check_cycle("ped", p, (k == 8) ? 1 : 0);
      next_cycle();
    end
    ped_req = 1'b0;

    // Request held through the walk: latch is empty afterwards, so BR goes
    // straight to AG at cycle 22.
    do_reset();
    for (int k = 0; k < 26; k++) begin
      int unsigned p;
      ta = 1'b1; tb = 1'b0; ped_req = (k < 14);
      p = (k < 4) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : (k < 14) ? 6 :
          (k < 18) ? 3 : (k < 21) ? 4 : (k == 21) ? 5 : 0;
      @(negedge clk); check_cycle("ped_hold", p, (k == 8) ? 1 : 0);
      next_cycle();
    end
    ped_req = 1'b0;

    // Same, plus a fresh request one cycle after the walk: served at the next
    // all-red (WK 22-27), then AG because B was last green.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      int unsigned p;
      ta = 1'b1; tb = 1'b0; ped_req = (k < 14) || (k == 15);
      p = (k < 4) ? 0 : (k < 7) ? 1 : (k == 7) ? 2 : (k < 14) ? 6 :
          (k < 18) ? 3 : (k < 21) ? 4 : (k == 21) ? 5 : (k < 28) ? 6 : 0;
      @(negedge clk); check_cycle("ped_again", p, (k == 8 || k == 22) ? 1 : 0);
      next_cycle();
    end
    ped_req = 1'b0;

    // Reset asserted during AY with a pending request: immediate return to AG,
    // and the request is discarded.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      int unsigned p;
      ta = 1'b1; tb = 1'b0; ped_req = (k == 1);
      p = (k < 4) ? 0 : 1;
      @(negedge clk); check_cycle("pre_rst", p, 0);
      if (k < 5) next_cycle();
    end
    ped_req = 1'b0;
    #2 rst = 1'b0;
    #1 check_cycle("async_rst", 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ta = 1'b1; tb = 1'b0;
      @(negedge clk); check_cycle("post_rst", 0, 0);
      next_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
